// File: rtl/fifo_pkg.sv
// fifo_pkg: types and default sizes shared by the synchronous FIFO
// controller and its pointer sub-module.
//   ptr_t          : write/read pointer with the wrap bit at the MSB
//   fifo_status_t  : {full, empty, almost_full, almost_empty}
package fifo_pkg;

   localparam int unsigned FIFO_ADDR_WIDTH = 8;
   localparam int unsigned FIFO_DEPTH      = 256;

   typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_status_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: registered wrap-bit pointer, incremented modulo 2**Width.
// Ports:
//   clk  in        clock, rising edge
//   rst  in        synchronous active-high reset, clears the pointer
//   inc  in        advance the pointer by one this cycle
//   ptr  out[W]    current pointer value (MSB is the wrap bit)
module fifo_ptr #(
   parameter int unsigned Width = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [Width-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: single-clock pointer and flag controller for a dual-port
// FIFO storage array. Drives the array write enable and both addresses and
// produces full/empty/threshold status plus an occupancy count.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   push, pop         producer / consumer requests
//   wr_en, rd_en      accepted push / pop (only combinational request paths)
//   wr_addr, rd_addr  pointers, bit [Addr_Width] is the wrap bit
//   full, empty, almost_full, almost_empty   status from registered pointers
//   count             occupancy 0..Depth
//   overflow, underflow  sticky error flags, only with FIFO_CTRL_ERR_FLAGS_EN
// Optional feature macro: FIFO_CTRL_ERR_FLAGS_EN
module fifo_sync_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned Addr_Width       = FIFO_ADDR_WIDTH,
   parameter int unsigned Depth            = FIFO_DEPTH,
   parameter int unsigned Almost_Full_Thr  = 224,
   parameter int unsigned Almost_Empty_Thr = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   output logic                wr_en,
   output logic                rd_en,
   output logic [Addr_Width:0] wr_addr,
   output logic [Addr_Width:0] rd_addr,
   output logic                full,
   output logic                empty,
   output logic                almost_full,
   output logic                almost_empty,
   output logic [Addr_Width:0] count
`ifdef FIFO_CTRL_ERR_FLAGS_EN
   ,
   output logic                overflow,
   output logic                underflow
`endif
);

   // Depth is implied by Addr_Width; reject inconsistent overrides at elaboration.
   if (Depth != (32'd1 << Addr_Width)) begin : g_depth_check
      $error("fifo_sync_ctrl: Depth must equal 2**Addr_Width");
   end

   localparam logic [Addr_Width:0] AF_THR = Almost_Full_Thr[Addr_Width:0];
   localparam logic [Addr_Width:0] AE_THR = Almost_Empty_Thr[Addr_Width:0];

   fifo_status_t status;

   fifo_ptr #(.Width(Addr_Width + 1)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .inc (wr_en),
      .ptr (wr_addr)
   );

   fifo_ptr #(.Width(Addr_Width + 1)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .inc (rd_en),
      .ptr (rd_addr)
   );

   // All status is derived from the registered pointers only, so no request
   // input reaches a flag and the flags can never disagree with count.
   always_comb begin
      count               = wr_addr - rd_addr;
      status.empty        = (wr_addr == rd_addr);
      status.full         = (wr_addr[Addr_Width] != rd_addr[Addr_Width]) &&
                            (wr_addr[Addr_Width-1:0] == rd_addr[Addr_Width-1:0]);
      status.almost_full  = (count >= AF_THR);
      status.almost_empty = (count <= AE_THR);
   end

   assign full         = status.full;
   assign empty        = status.empty;
   assign almost_full  = status.almost_full;
   assign almost_empty = status.almost_empty;

   // A pop is judged against the registered empty flag, so it is never
   // satisfied by a push arriving in the same cycle.
   assign wr_en = push & ~status.full;
   assign rd_en = pop  & ~status.empty;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push && status.full)  overflow  <= 1'b1;
         if (pop  && status.empty) underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Bench for fifo_sync_ctrl with a behavioural storage array beside it.
// Accepted pushes queue their data; a monitor pops and compares data_out
// whenever the controller asserts rd_en.
module tb_fifo_sync_ctrl;
   import fifo_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic [7:0] din = '0;
   logic       wr_en, rd_en, full, empty, almost_full, almost_empty;
   ptr_t       wr_addr, rd_addr, count;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
   logic       overflow, underflow;
`endif

   int checks = 0;
   int errors = 0;
   int mcount = 0;
   logic [7:0] exp_q[$];

   logic [7:0] mem [256];
   logic [7:0] data_out;

   always #5 clk = ~clk;

   fifo_sync_ctrl #(
      .Addr_Width      (8),
      .Depth           (256),
      .Almost_Full_Thr (224),
      .Almost_Empty_Thr(32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .pop         (pop),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .wr_addr     (wr_addr),
      .rd_addr     (rd_addr),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .count       (count)
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      ,
      .overflow    (overflow),
      .underflow   (underflow)
`endif
   );

   // Storage array: write at the edge, show-ahead read.
   always @(posedge clk) if (wr_en) mem[wr_addr[7:0]] <= din;
   assign data_out = mem[rd_addr[7:0]];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: every accepted pop must present the oldest queued word.
   always @(negedge clk) begin
      if (rd_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_data: got %0h expected none (queue empty)", data_out);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (data_out !== e) begin
               errors++;
               $display("FAIL rd_data: got %0h expected %0h", data_out, e);
            end
         end
      end
   end

   // Called at posedge+1; returns at the next posedge+1.
   task automatic step(input logic p, input logic q, input logic [7:0] d);
      bit ew, er;
      push = p; pop = q; din = d;
      ew = p && (mcount < 256);
      er = q && (mcount > 0);
      #2;
      chk("wr_en", wr_en, ew);
      chk("rd_en", rd_en, er);
      if (ew) exp_q.push_back(d);
      @(posedge clk); #1;
      mcount = mcount + int'(ew) - int'(er);
      chk("count", count, mcount);
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; push = 1'b0; pop = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      mcount = 0;
      exp_q.delete();
   endtask

   initial begin
      @(posedge clk); #1;
      do_reset();
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 9'h000);
      chk("rst_wr_addr", wr_addr, 9'h000);
      chk("rst_rd_addr", rd_addr, 9'h000);
      chk("rst_almost_empty", almost_empty, 1);
      chk("rst_almost_full", almost_full, 0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk("rst_overflow", overflow, 0);
      chk("rst_underflow", underflow, 0);
`endif

      // Fill 0..255; thresholds at 224 (almost_full) and 32 (almost_empty).
      for (int i = 0; i < 256; i++) begin
         step(1, 0, 8'(i));
         chk("almost_full", almost_full, (i + 1 >= 224) ? 1 : 0);
         chk("almost_empty", almost_empty, (i + 1 <= 32) ? 1 : 0);
         if (i == 0) chk("empty_after_first_push", empty, 0);
      end
      chk("fill_full", full, 1);
      chk("fill_count", count, 9'h100);
      chk("fill_wr_addr", wr_addr, 9'h100);
      chk("fill_rd_addr", rd_addr, 9'h000);

      step(1, 0, 8'hAA);
      chk("push_full_count", count, 9'h100);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk("overflow_set", overflow, 1);
`endif

      for (int i = 0; i < 256; i++) step(0, 1, 8'h00);
      chk("drain_empty", empty, 1);
      chk("drain_rd_addr", rd_addr, 9'h100);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk("overflow_sticky", overflow, 1);
      chk("underflow_clear", underflow, 0);
`endif
      step(0, 1, 8'h00);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk("underflow_set", underflow, 1);
`endif

      // Simultaneous push/pop at count 5.
      for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h10 + i));
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 8'(8'h40 + i));
         chk("pp_count5", count, 5);
      end
      for (int i = 0; i < 5; i++) step(0, 1, 8'h00);
      chk("pp_drained", empty, 1);

      // Simultaneous at empty: only the push is taken.
      step(1, 1, 8'h77);
      chk("pp_empty_count", count, 1);
      step(0, 1, 8'h00);

      // Simultaneous at full: only the pop is taken.
      for (int i = 0; i < 256; i++) step(1, 0, 8'(255 - i));
      chk("refill_full", full, 1);
      step(1, 1, 8'h55);
      chk("pp_full_count", count, 9'h0FF);
      chk("pp_full_notfull", full, 0);
      for (int i = 0; i < 255; i++) step(0, 1, 8'h00);
      chk("redrain_empty", empty, 1);

      // Wrap: 300 push/pop pairs from a clean reset.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         step(1, 0, 8'(i * 3));
         step(0, 1, 8'h00);
         if (i == 254) chk("wrap_wr_pre", wr_addr, 9'h0FF);
         if (i == 255) begin
            chk("wrap_wr_256", wr_addr, 9'h100);
            chk("wrap_rd_256", rd_addr, 9'h100);
         end
      end
      chk("wrap_wr_300", wr_addr, 9'h12C);
      chk("wrap_rd_300", rd_addr, 9'h12C);

      // Reset with 100 entries held; rst overrides a concurrent push.
      for (int i = 0; i < 100; i++) step(1, 0, 8'(i));
      chk("pre_rst_count", count, 100);
      rst = 1'b1; push = 1'b1; pop = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; push = 1'b0;
      mcount = 0;
      exp_q.delete();
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_wr_addr", wr_addr, 9'h000);
      step(1, 0, 8'hC3);
      step(0, 1, 8'h00);

      repeat (3) @(posedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
